// File: rtl/ccheck_pkg.sv
// ccheck_pkg: stripper FSM states and the ASCII constants it matches on
package ccheck_pkg;
  typedef enum logic [2:0] {NORMAL, SLASH, BLOCK, BLOCK_STAR, LINE} strip_state_t;
  localparam logic [7:0] CH_SLASH = 8'h2F;
  localparam logic [7:0] CH_STAR  = 8'h2A;
  localparam logic [7:0] CH_NL    = 8'h0A;
  localparam logic [7:0] CH_SEMI  = 8'h3B;
endpackage

// File: rtl/byte_skid2.sv
// byte_skid2: output register plus one pending slot; each push carries 0, 1 or 2 bytes
module byte_skid2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] push_n,
  input  logic [7:0] push_d0,
  input  logic [7:0] push_d1,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data
);
  logic       pend_v;
  logic [7:0] pend_d;
  logic       free;
  assign free     = ~out_valid | out_ready;
  assign in_ready = ~pend_v & free;
  // pend_v is only ever set together with out_valid, so out_ready alone drains it
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      pend_v    <= 1'b0;
      pend_d    <= 8'h00;
    end else if (pend_v) begin
      if (out_ready) begin
        out_data <= pend_d;
        pend_v   <= 1'b0;
      end
    end else if (free) begin
      out_valid <= |push_n;
      if (|push_n) out_data <= push_d0;
      if (push_n == 2'd2) begin
        pend_v <= 1'b1;
        pend_d <= push_d1;
      end
    end
endmodule

// File: rtl/comment_strip.sv
// comment_strip: replaces each C block comment with REPLACE_CHAR, passing all other bytes.
// Defining LINE_COMMENT_EN also strips // comments up to (not including) the newline.
module comment_strip import ccheck_pkg::*; #(
  parameter logic [7:0] REPLACE_CHAR = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       in_comment
);
  strip_state_t state, nxt;
  logic       fire;
  logic [1:0] emit_n, push_n;
  logic [7:0] d0, d1;
  assign fire       = in_valid & in_ready;
  assign push_n     = fire ? emit_n : 2'd0;
  assign in_comment = state inside {BLOCK, BLOCK_STAR, LINE};
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= NORMAL;
    else if (fire) state <= nxt;
  always_comb begin
    nxt    = state;
    emit_n = 2'd0;
    d0     = in_data;
    d1     = in_data;
    case (state)
      NORMAL: begin
        if (in_data == CH_SLASH) nxt = SLASH;
        else emit_n = 2'd1;
      end
      SLASH: begin
        d0 = CH_SLASH;
        if (in_data == CH_STAR) nxt = BLOCK;
`ifdef LINE_COMMENT_EN
        else if (in_data == CH_SLASH) nxt = LINE;
`else
        else if (in_data == CH_SLASH) emit_n = 2'd1;
`endif
        else begin
          emit_n = 2'd2;
          nxt    = NORMAL;
        end
      end
      BLOCK: nxt = (in_data == CH_STAR) ? BLOCK_STAR : BLOCK;
      BLOCK_STAR: begin
        if (in_data == CH_SLASH) begin
          nxt    = NORMAL;
          emit_n = 2'd1;
          d0     = REPLACE_CHAR;
        end else if (in_data != CH_STAR) nxt = BLOCK;
      end
`ifdef LINE_COMMENT_EN
      LINE: begin
        if (in_data == CH_NL) begin
          nxt    = NORMAL;
          emit_n = 2'd1;
        end
      end
`endif
      default: nxt = NORMAL;
    endcase
  end
  byte_skid2 u_skid (
    .clk(clk),
    .reset(reset),
    .push_n(push_n),
    .push_d0(d0),
    .push_d1(d1),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data)
  );
endmodule
